// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: debug readout engine. It walks every register through the
// register file's debug read port and streams each value, then a checksum beat.
`default_nettype none

module regfile_dump_reader #(
  parameter int W = 8,
  parameter int A = 3
) (
  input  logic         Clk,
  input  logic         ResetN,
  input  logic         Start,
  input  logic         Halted,
  input  logic         Abort,
  output logic [A-1:0] RdAddr,
  input  logic [W-1:0] RdData,
  output logic [W-1:0] OutData,
  output logic [A-1:0] OutAddr,
  output logic         OutValid,
  input  logic         OutReady,
  output logic         OutLast,
  output logic         Busy,
  output logic         Done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_CSUM  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [A-1:0] LAST_IDX = {A{1'b1}};

  state_e         state_q, state_d;
  logic [A-1:0]   idx_q, idx_d;
  logic [W-1:0]   sum_q, sum_d;
  logic [W-1:0]   data_q, data_d;
  logic [A-1:0]   addr_q, addr_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic           hs;

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sum_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign hs = valid_q & OutReady;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    last_d  = last_q;

    case (state_q)
      S_IDLE: begin
        if (Start && Halted) begin
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        data_d  = RdData;
        addr_d  = idx_q;
        sum_d   = sum_q + RdData;
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            // checksum beat reuses the held valid, no bubble before it
            data_d  = sum_q;
            addr_d  = '0;
            last_d  = 1'b1;
            state_d = S_CSUM;
          end else begin
            idx_d   = idx_q + A'(1);
            valid_d = 1'b0;
            state_d = S_FETCH;
          end
        end
      end
      S_CSUM: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort beats any handshake in the same cycle
    if (Abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = '0;
      sum_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  assign RdAddr   = (state_q == S_FETCH) ? idx_q : '0;
  assign OutData  = data_q;
  assign OutAddr  = addr_q;
  assign OutValid = valid_q;
  assign OutLast  = last_q;
  assign Busy     = (state_q != S_IDLE);
  assign Done     = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: expected beats are queued at Start,
// a negedge monitor pops and compares every accepted beat.
`default_nettype none

module tb_regfile_dump_reader;

  logic       Clk = 1'b0;
  logic       ResetN, Start, Halted, Abort, OutReady;
  logic [2:0] RdAddr, OutAddr;
  logic [7:0] RdData, OutData;
  logic       OutValid, OutLast, Busy, Done;

  logic [7:0] regs [8];

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];

  int checks = 0;
  int errors = 0;

  int   ready_mode = 0;   // 0 always, 1 toggle+stall on beat3, 3 random, 4 hold on stall_addr
  int   stall_addr = 0;
  int   stall_cnt  = 0;
  bit   stalled3   = 0;
  bit   exp_done   = 0;
  bit   done_seen  = 0;
  bit   prev_stall = 0;
  logic [7:0] prev_data;
  logic [2:0] prev_addr;

  regfile_dump_reader #(.W(8), .A(3)) dut (
    .Clk(Clk), .ResetN(ResetN), .Start(Start), .Halted(Halted), .Abort(Abort),
    .RdAddr(RdAddr), .RdData(RdData), .OutData(OutData), .OutAddr(OutAddr),
    .OutValid(OutValid), .OutReady(OutReady), .OutLast(OutLast),
    .Busy(Busy), .Done(Done)
  );

  assign RdData = regs[RdAddr];

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // reference model: the dump is just every register in order, then their byte sum
  task automatic push_dump();
    int s = 0;
    beat_t b;
    for (int i = 0; i < 8; i++) begin
      b.addr = i[2:0];
      b.data = regs[i];
      b.last = 1'b0;
      exp_q.push_back(b);
      s = s + regs[i];
    end
    b.addr = 3'd0;
    b.data = s[7:0];
    b.last = 1'b1;
    exp_q.push_back(b);
  endtask

  task automatic start_dump();
    push_dump();
    done_seen = 0;
    stalled3  = 0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin
      tick();
      n++;
    end
    chk("done_timeout", {31'd0, done_seen}, 32'd1);
    chk("queue_empty", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_beat(input int addr, input int budget);
    int n = 0;
    while (!(OutValid && !OutLast && OutAddr == addr[2:0]) && n < budget) begin
      tick();
      n++;
    end
    chk("beat_wait_timeout", {31'd0, (n < budget)}, 32'd1);
  endtask

  always @(posedge Clk) begin
    #1;
    case (ready_mode)
      0: OutReady = 1'b1;
      1: begin
        if (stall_cnt > 0) begin
          OutReady  = 1'b0;
          stall_cnt = stall_cnt - 1;
        end else if (OutValid && !OutLast && OutAddr == 3'd3 && !stalled3) begin
          OutReady  = 1'b0;
          stall_cnt = 4;
          stalled3  = 1;
        end else begin
          OutReady = ~OutReady;
        end
      end
      3: OutReady = 1'($urandom_range(0, 1));
      default: OutReady = !(OutValid && !OutLast && OutAddr == stall_addr[2:0]);
    endcase
  end

  always @(negedge Clk) begin
    beat_t b;
    chk("done_pulse", {31'd0, Done}, {31'd0, exp_done});
    exp_done = 0;
    if (Done) done_seen = 1;
    if (prev_stall && OutValid) begin
      chk("stall_data_stable", {24'd0, OutData}, {24'd0, prev_data});
      chk("stall_addr_stable", {29'd0, OutAddr}, {29'd0, prev_addr});
    end
    prev_stall = OutValid && !OutReady;
    prev_data  = OutData;
    prev_addr  = OutAddr;
    if (OutValid && OutReady) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'd1, 32'd0);
      end else begin
        b = exp_q.pop_front();
        chk("beat_addr", {29'd0, OutAddr}, {29'd0, b.addr});
        chk("beat_data", {24'd0, OutData}, {24'd0, b.data});
        chk("beat_last", {31'd0, OutLast}, {31'd0, b.last});
        if (b.last) exp_done = 1;
      end
    end
  end

  initial begin
    ResetN = 1'b0; Start = 1'b0; Halted = 1'b1; Abort = 1'b0; OutReady = 1'b1;
    for (int i = 0; i < 8; i++) regs[i] = 8'(8'h11 * (i + 1));
    tick();
    tick();
    chk("rst_valid", {31'd0, OutValid}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_data", {24'd0, OutData}, 32'd0);
    chk("rst_rdaddr", {29'd0, RdAddr}, 32'd0);
    ResetN = 1'b1;
    tick();

    // ascending pattern, ready high, latency check
    ready_mode = 0;
    start_dump();
    chk("lat_fetch_valid", {31'd0, OutValid}, 32'd0);
    chk("lat_busy", {31'd0, Busy}, 32'd1);
    tick();
    chk("lat_first_valid", {31'd0, OutValid}, 32'd1);
    wait_done(100);
    tick();

    // toggling ready with long stall on beat 3
    ready_mode = 1;
    start_dump();
    wait_done(200);
    ready_mode = 0;
    tick();

    // not halted: request ignored
    Halted = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("nohalt_busy", {31'd0, Busy}, 32'd0);
      chk("nohalt_valid", {31'd0, OutValid}, 32'd0);
      tick();
    end
    Halted = 1'b1;
    start_dump();
    wait_done(100);

    // all 0xFF, checksum wraps
    for (int i = 0; i < 8; i++) regs[i] = 8'hFF;
    ready_mode = 3;
    start_dump();
    wait_done(300);

    // abort while stalled on beat 4, then restart from scratch
    for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
    ready_mode = 4;
    stall_addr = 4;
    start_dump();
    wait_beat(4, 100);
    tick();
    Abort = 1'b1;
    exp_q.delete();
    tick();
    Abort = 1'b0;
    chk("abort_valid", {31'd0, OutValid}, 32'd0);
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_last", {31'd0, OutLast}, 32'd0);
    tick();
    tick();
    ready_mode = 0;
    start_dump();
    wait_done(100);

    // reset mid-dump while stalled on beat 2
    for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
    ready_mode = 4;
    stall_addr = 2;
    start_dump();
    wait_beat(2, 100);
    ResetN = 1'b0;
    exp_q.delete();
    tick();
    chk("mrst_data", {24'd0, OutData}, 32'd0);
    chk("mrst_addr", {29'd0, OutAddr}, 32'd0);
    chk("mrst_valid", {31'd0, OutValid}, 32'd0);
    chk("mrst_last", {31'd0, OutLast}, 32'd0);
    chk("mrst_busy", {31'd0, Busy}, 32'd0);
    chk("mrst_done", {31'd0, Done}, 32'd0);
    chk("mrst_rdaddr", {29'd0, RdAddr}, 32'd0);
    ResetN = 1'b1;
    ready_mode = 0;
    tick();
    start_dump();
    wait_done(100);

    // random dumps, random backpressure, Halted dropped mid-dump
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
      ready_mode = 3;
      start_dump();
      Halted = 1'($urandom_range(0, 1));
      wait_done(300);
      Halted = 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
